// File: rtl/pio_pkg.sv
// Shared definitions for the pulse-capable output PIO: register map,
// pulse engine states and STATUS field positions.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd1;
  localparam logic [2:0] ADDR_PULSE_TRIG = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  // STATUS layout: busy flag at bit 0, live inversion mask starting at bit 1
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_MASK_LSB = 1;

endpackage

// File: rtl/pulse_timer.sv
// Timed inversion engine: loads a mask and a cycle count on trigger,
// counts down, and drops the mask when the count runs out.
module pulse_timer
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trig_i,
  input  logic [DATA_WIDTH-1:0] trig_mask_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic                  busy_o
);

  pulse_state_e          state_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  trig_ok;

  // A trigger only counts when it selects at least one bit and has a nonzero length
  assign trig_ok = trig_i && (trig_mask_i != '0) && (len_i != '0);

  // Pulse FSM: load/retrigger wins over expiry; the mask is held for exactly len cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_ok) begin
            mask_q  <= trig_mask_i;
            cnt_q   <= len_i;
            state_q <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (trig_ok) begin
            mask_q <= mask_q | trig_mask_i;
            cnt_q  <= len_i;
          end else if (cnt_q == CNT_WIDTH'(1)) begin
            mask_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          mask_q  <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mask_o = mask_q;
  assign busy_o = (state_q == ST_PULSE);

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware timed-pulse
// engine that temporarily inverts selected output bits.
module pio_out_pulse
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CNT_WIDTH   = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0] mask;
  logic                  busy;
  logic                  trig;
  logic [DATA_WIDTH:0]   status_w;
  logic [DATA_WIDTH+31:0] data_ext;
  logic [CNT_WIDTH+31:0]  len_ext;
  logic [DATA_WIDTH+32:0] status_ext;
  logic                  unused_wd;

  assign wr_en = chipselect && !write_n;
  assign wd    = writedata[DATA_WIDTH-1:0];
  assign trig  = wr_en && (address == ADDR_PULSE_TRIG);

  // Upper write-data bits beyond the register widths are intentionally dropped
  assign unused_wd = ^writedata;

  pulse_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_pulse_timer (
    .clk_i       (clk),
    .rst_i       (reset),
    .trig_i      (trig),
    .trig_mask_i (wd),
    .len_i       (len_q),
    .mask_o      (mask),
    .busy_o      (busy)
  );

  // Next-state for the base data and pulse length registers
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      data_d = wd;
        ADDR_OUTSET:    data_d = data_q | wd;
        ADDR_OUTCLEAR:  data_d = data_q & ~wd;
        ADDR_PULSE_LEN: len_d  = writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Zero-extended views; widening then truncating handles widths up to 32 uniformly
  assign status_w   = {mask, busy};
  assign data_ext   = {32'b0, data_q};
  assign len_ext    = {32'b0, len_q};
  assign status_ext = {32'b0, status_w};

  // Read mux: no read strobe, reads are side-effect free
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:      readdata_d = data_ext[31:0];
      ADDR_PULSE_LEN: readdata_d = len_ext[31:0];
      ADDR_STATUS:    readdata_d = status_ext[31:0];
      default:        readdata_d = '0;
    endcase
  end

  // Register state and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      len_q      <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      len_q      <= len_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ mask;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed bench for pio_out_pulse: register access, set/clear, pulse
// timing, retrigger, degenerate triggers, reset mid-pulse.
module tb_pio_out_pulse;

  localparam int          DW = 8;
  localparam int          CW = 24;
  localparam logic [7:0]  RV = 8'h00;

  localparam logic [2:0] A_DATA = 3'd0, A_LEN = 3'd1, A_TRIG = 3'd2, A_STAT = 3'd3,
                         A_SET = 3'd4, A_CLR = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [DW-1:0] out_port;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] rd;

  pio_out_pulse #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  initial begin
    // Reset and idle read of every address
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out_port), 32'(RV));
    check("rst_rd", readdata, 32'h0);
    @(negedge clk); reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), rd);
      check($sformatf("rst_read_a%0d", a), rd, 32'h0);
    end

    // Set / clear
    bus_wr(A_DATA, 32'hA5);
    check("data_a5", 32'(out_port), 32'hA5);
    bus_wr(A_SET, 32'h0A);
    check("outset", 32'(out_port), 32'hAF);
    bus_wr(A_CLR, 32'h81);
    check("outclr", 32'(out_port), 32'h2E);
    bus_rd(A_DATA, rd);
    check("rd_data", rd, 32'h2E);
    bus_rd(A_SET, rd);
    check("rd_outset_wo", rd, 32'h0);

    // Basic pulse, 5 cycles
    bus_wr(A_DATA, 32'h00);
    bus_wr(A_LEN, 32'd5);
    bus_wr(A_TRIG, 32'h01);
    check("pulse_e0", 32'(out_port), 32'h01);
    address = A_STAT;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("pulse_out_k%0d", k), 32'(out_port), (k < 5) ? 32'h01 : 32'h00);
      check($sformatf("pulse_stat_k%0d", k), readdata, 32'h03);
    end
    @(posedge clk); #1;
    check("pulse_stat_after", readdata, 32'h00);

    // Retrigger at cycle 8 of a 10-cycle pulse
    bus_wr(A_LEN, 32'd10);
    bus_wr(A_TRIG, 32'h01);
    repeat (7) @(posedge clk);
    bus_wr(A_TRIG, 32'h02);
    check("retrig_e0", 32'(out_port), 32'h03);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("retrig_k%0d", k), 32'(out_port), (k < 10) ? 32'h03 : 32'h00);
    end

    // Degenerate triggers
    bus_wr(A_LEN, 32'd0);
    bus_wr(A_TRIG, 32'hFF);
    check("len0_out", 32'(out_port), 32'h00);
    bus_rd(A_STAT, rd);
    check("len0_busy", rd, 32'h0);
    bus_wr(A_LEN, 32'd3);
    bus_wr(A_TRIG, 32'h00);
    check("mask0_out", 32'(out_port), 32'h00);
    bus_rd(A_STAT, rd);
    check("mask0_busy", rd, 32'h0);
    bus_wr(A_LEN, 32'h0100_0003);
    bus_rd(A_LEN, rd);
    check("len_trunc", rd, 32'h0000_0003);

    // Reset at cycle 20 of a 100-cycle pulse
    bus_wr(A_LEN, 32'd100);
    bus_wr(A_TRIG, 32'hF0);
    check("long_e0", 32'(out_port), 32'hF0);
    repeat (19) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out", 32'(out_port), 32'(RV));
    check("midrst_rd", readdata, 32'h0);
    @(negedge clk); reset = 1'b0;
    bus_rd(A_STAT, rd);
    check("midrst_busy", rd, 32'h0);
    bus_rd(A_LEN, rd);
    check("midrst_len", rd, 32'h0);
    check("midrst_out2", 32'(out_port), 32'(RV));

    // DATA write while pulsing
    bus_wr(A_LEN, 32'd5);
    bus_wr(A_TRIG, 32'hF0);
    bus_wr(A_DATA, 32'h0F);
    check("dpulse_ff", 32'(out_port), 32'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("dpulse_e4", 32'(out_port), 32'hFF);
    @(posedge clk); #1;
    check("dpulse_exp", 32'(out_port), 32'h0F);
    bus_rd(A_DATA, rd);
    check("dpulse_rd", rd, 32'h0F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
